serial_tx_unit: RTL and testbench

Serializer on the transmit side of the calculator's controller handshake. When the read/write flow controller raises its transmit request, this block captures the parallel result word and shifts it out one bit per clock, optionally followed by an even-parity bit. It then returns a one-cycle completion pulse that the controller consumes as its transmit-done input. The block sits between the controller/memory datapath and the serial output pin.

---
 rtl/serial_tx_unit.sv | 121 ++++++++++++
 tb/tb_serial_tx_unit.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/serial_tx_unit.sv
// rtl/serial_tx_unit.sv - serializer that shifts out a captured word, an optional even-parity bit, then pulses done
// All outputs are registered; the first data bit appears on the accepting edge itself.
module serial_tx_unit #(
  parameter int WIDTH     = 8,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_tx_data,
  input  logic [WIDTH-1:0] i_data_in,
  input  logic             i_lsb_first,
  output logic             o_d_out,
  output logic             o_out_valid,
  output logic             o_tx_done,
  output logic             o_busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_PARITY, S_DONE} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_shift, w_shift_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic             r_lsb, w_lsb_nxt;
  logic             r_par, w_par_nxt;
  logic             r_dout, w_dout_nxt;
  logic             r_valid, w_valid_nxt;
  logic             r_done, w_done_nxt;
  logic             r_busy, w_busy_nxt;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
      r_lsb   <= 1'b0;
      r_par   <= 1'b0;
      r_dout  <= 1'b0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_cnt   <= w_cnt_nxt;
      r_lsb   <= w_lsb_nxt;
      r_par   <= w_par_nxt;
      r_dout  <= w_dout_nxt;
      r_valid <= w_valid_nxt;
      r_done  <= w_done_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_cnt;
    w_lsb_nxt   = r_lsb;
    w_par_nxt   = r_par;
    w_dout_nxt  = 1'b0;
    w_valid_nxt = 1'b0;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_tx_data) begin
          w_state_nxt = S_SHIFT;
          w_shift_nxt = i_data_in;
          w_lsb_nxt   = i_lsb_first;
          w_cnt_nxt   = '0;
          w_par_nxt   = 1'b0;
          w_dout_nxt  = i_lsb_first ? i_data_in[0] : i_data_in[WIDTH-1];
          w_valid_nxt = 1'b1;
        end
      end
      S_SHIFT: begin
        // r_dout is the bit currently on the pin; fold it into the parity
        w_par_nxt = r_par ^ r_dout;
        if (r_cnt == LAST_BIT) begin
          if (PARITY_EN) begin
            w_state_nxt = S_PARITY;
            w_dout_nxt  = r_par ^ r_dout;
            w_valid_nxt = 1'b1;
          end else begin
            w_state_nxt = S_DONE;
            w_done_nxt  = 1'b1;
          end
        end else begin
          w_cnt_nxt   = r_cnt + CW'(1);
          w_valid_nxt = 1'b1;
          if (r_lsb) begin
            w_shift_nxt = r_shift >> 1;
            w_dout_nxt  = r_shift[1];
          end else begin
            w_shift_nxt = r_shift << 1;
            w_dout_nxt  = r_shift[WIDTH-2];
          end
        end
      end
      S_PARITY: begin
        w_state_nxt = S_DONE;
        w_done_nxt  = 1'b1;
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  assign o_d_out     = r_dout;
  assign o_out_valid = r_valid;
  assign o_tx_done   = r_done;
  assign o_busy      = r_busy;

endmodule

// File: tb/tb_serial_tx_unit.sv
// tb/tb_serial_tx_unit.sv - scoreboard bench for serial_tx_unit with and without parity
module tb_serial_tx_unit;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         tx_p, lsb_p, dout_p, valid_p, done_p, busy_p;
  logic [W-1:0] data_p;
  logic         tx_n, lsb_n, dout_n, valid_n, done_n, busy_n;
  logic [W-1:0] data_n;

  int n_checks = 0;
  int n_errors = 0;
  bit q_p[$];
  bit q_n[$];

  always #5 clk = ~clk;

  serial_tx_unit #(.WIDTH(W), .PARITY_EN(1'b1)) dut_p (
    .i_clk(clk), .i_reset(rst), .i_tx_data(tx_p), .i_data_in(data_p), .i_lsb_first(lsb_p),
    .o_d_out(dout_p), .o_out_valid(valid_p), .o_tx_done(done_p), .o_busy(busy_p)
  );

  serial_tx_unit #(.WIDTH(W), .PARITY_EN(1'b0)) dut_n (
    .i_clk(clk), .i_reset(rst), .i_tx_data(tx_n), .i_data_in(data_n), .i_lsb_first(lsb_n),
    .o_d_out(dout_n), .o_out_valid(valid_n), .o_tx_done(done_n), .o_busy(busy_n)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_p(input logic [W-1:0] d, input logic lsb);
    for (int i = 0; i < W; i++) q_p.push_back(lsb ? d[i] : d[W-1-i]);
    q_p.push_back(^d);
  endtask

  task automatic push_n(input logic [W-1:0] d, input logic lsb);
    for (int i = 0; i < W; i++) q_n.push_back(lsb ? d[i] : d[W-1-i]);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      check("p_valid_done_overlap", 32'(valid_p & done_p), 32'd0);
      if (valid_p) begin
        if (q_p.size() == 0) check("p_unexpected_bit", 32'd1, 32'd0);
        else check("p_dout", 32'(dout_p), 32'(q_p.pop_front()));
      end
      if (valid_n) begin
        if (q_n.size() == 0) check("n_unexpected_bit", 32'd1, 32'd0);
        else check("n_dout", 32'(dout_n), 32'(q_n.pop_front()));
      end
    end
  end

  task automatic run_p(input logic [W-1:0] d, input logic lsb, input bit chg);
    tx_p = 1'b1; data_p = d; lsb_p = lsb;
    push_p(d, lsb);
    tick();
    tx_p = 1'b0;
    check("p_busy_e0", 32'(busy_p), 32'd1);
    check("p_valid_e0", 32'(valid_p), 32'd1);
    check("p_done_e0", 32'(done_p), 32'd0);
    for (int k = 1; k <= W + 1; k++) begin
      tick();
      if (chg && k == 2) data_p = '0;
      check("p_done", 32'(done_p), 32'(k == W + 1));
      check("p_busy", 32'(busy_p), 32'd1);
      check("p_valid", 32'(valid_p), 32'(k <= W));
    end
    tick();
    check("p_busy_end", 32'(busy_p), 32'd0);
    check("p_done_end", 32'(done_p), 32'd0);
    check("p_queue_drained", 32'(q_p.size()), 32'd0);
  endtask

  initial begin
    bit got;
    rst = 1'b1; tx_p = 1'b1; data_p = 8'hFF; lsb_p = 1'b0;
    tx_n = 1'b0; data_n = '0; lsb_n = 1'b0;

    repeat (2) begin
      tick();
      check("rst_dout", 32'(dout_p), 32'd0);
      check("rst_valid", 32'(valid_p), 32'd0);
      check("rst_done", 32'(done_p), 32'd0);
      check("rst_busy", 32'(busy_p), 32'd0);
      check("rst_busy_n", 32'(busy_n), 32'd0);
    end
    rst = 1'b0;
    run_p(8'hFF, 1'b0, 1'b0);

    run_p(8'hC1, 1'b0, 1'b0);
    run_p(8'hC1, 1'b1, 1'b1);
    for (int r = 0; r < 4; r++) run_p(W'($urandom), 1'($urandom), 1'b0);

    // abort a transfer with reset after its fifth bit
    tx_p = 1'b1; data_p = 8'hC1; lsb_p = 1'b0;
    push_p(8'hC1, 1'b0);
    tick();
    tx_p = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    q_p.delete();
    tick();
    check("abort_dout", 32'(dout_p), 32'd0);
    check("abort_valid", 32'(valid_p), 32'd0);
    check("abort_busy", 32'(busy_p), 32'd0);
    check("abort_done", 32'(done_p), 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      check("abort_no_done", 32'(done_p), 32'd0);
      check("abort_idle", 32'(busy_p), 32'd0);
    end
    run_p(8'h3C, 1'b0, 1'b0);

    // controller handshake: hold request until done, then drop it
    tx_p = 1'b1; data_p = W'($urandom); lsb_p = 1'($urandom);
    push_p(data_p, lsb_p);
    got = 1'b0;
    for (int k = 0; k < 30 && !got; k++) begin
      tick();
      if (done_p) begin
        got = 1'b1;
        tx_p = 1'b0;
      end
    end
    check("hs_done_seen", 32'(got), 32'd1);
    for (int k = 0; k < 15; k++) begin
      tick();
      check("hs_busy_low", 32'(busy_p), 32'd0);
      check("hs_single_done", 32'(done_p), 32'd0);
    end
    check("hs_queue_drained", 32'(q_p.size()), 32'd0);

    // no-parity instance: request held for back-to-back transfers
    tx_n = 1'b1; data_n = 8'hA5; lsb_n = 1'b0;
    push_n(8'hA5, 1'b0);
    push_n(8'hA5, 1'b0);
    for (int k = 0; k <= 20; k++) begin
      tick();
      if (k == 19) tx_n = 1'b0;
      check("n_done", 32'(done_n), 32'(k == 8 || k == 18));
      check("n_busy", 32'(busy_n), 32'(!(k == 9 || k >= 19)));
      check("n_valid", 32'(valid_n), 32'(k <= 7 || (k >= 10 && k <= 17)));
    end
    tick();
    check("n_queue_drained", 32'(q_n.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
